safe_code_entry: RTL and testbench

Front-end code-entry stage of the digital safe lock. Collects single-bit key presses from the keypad, assembles them MSB-first into an N-bit code, and on an enter key issues a one-cycle `par_valid` pulse with `par_data` to the parallel-to-serial stage. After each issue it holds off further entries long enough for the downstream serialiser to drain. Malformed entries are rejected with an error pulse.

---
 rtl/safe_code_entry_if.sv | 19 +
 rtl/safe_code_entry.sv | 135 +++++++++++++
 tb/tb_safe_code_entry.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/safe_code_entry_if.sv
// Keypad-to-safe code entry bus: key strobes in, parallel code and status out.
interface safe_code_entry_if #(parameter int N = 4) ();
  localparam int CW = $clog2(N + 1);

  logic          key_valid;
  logic          key_bit;
  logic          key_enter;
  logic          key_clear;
  logic          par_valid;
  logic [N-1:0]  par_data;
  logic          entry_err;
  logic          busy;
  logic [CW-1:0] digit_cnt;

  modport master (output key_valid, key_bit, key_enter, key_clear,
                  input  par_valid, par_data, entry_err, busy, digit_cnt);
  modport slave  (input  key_valid, key_bit, key_enter, key_clear,
                  output par_valid, par_data, entry_err, busy, digit_cnt);
endinterface

// File: rtl/safe_code_entry.sv
// Code-entry front end: assembles N key bits MSB-first and issues them on enter.
// Optional inactivity timeout enabled by defining SAFE_ENTRY_TIMEOUT_EN.
module safe_code_entry #(
  parameter int N              = 4,
  parameter int GAP_CYCLES     = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               rst,
  safe_code_entry_if.slave  bus
);
  localparam int CW = $clog2(N + 1);
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  if (N < 2 || GAP_CYCLES < N + 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("safe_code_entry: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, COLLECT, FULL, SEND, GAP} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [N-1:0]  par_data_q, par_data_d;
  logic          par_valid_q, par_valid_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

`ifdef SAFE_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] to_q, to_d;
`endif

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    par_data_d  = par_data_q;
    par_valid_d = 1'b0;
    err_d       = 1'b0;
`ifdef SAFE_ENTRY_TIMEOUT_EN
    to_d        = '0;
`endif
    case (state_q)
      IDLE, COLLECT, FULL: begin
        if (bus.key_clear) begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (bus.key_enter) begin
          if (state_q == FULL) begin
            par_data_d  = shreg_q;
            par_valid_d = 1'b1;
            state_d     = SEND;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
          shreg_d = '0;
          cnt_d   = '0;
        end else if (bus.key_valid) begin
          if (state_q == FULL) begin
            err_d   = 1'b1;
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            shreg_d = (shreg_q << 1) | N'(bus.key_bit);
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(N - 1)) ? FULL : COLLECT;
          end
        end
`ifdef SAFE_ENTRY_TIMEOUT_EN
        // Idle cycles with a partial/full entry pending age it out.
        else if (state_q != IDLE) begin
          to_d = to_q + 1'b1;
          if (to_d == TW'(TIMEOUT_CYCLES - 1)) begin
            to_d    = '0;
            err_d   = 1'b1;
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
`endif
      end
      SEND: begin
        state_d = GAP;
        gap_d   = GW'(GAP_CYCLES - 2);
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SEND) || (state_d == GAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      par_data_q  <= '0;
      par_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SAFE_ENTRY_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      par_data_q  <= par_data_d;
      par_valid_q <= par_valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
`ifdef SAFE_ENTRY_TIMEOUT_EN
      to_q        <= to_d;
`endif
    end
  end

  assign bus.par_valid = par_valid_q;
  assign bus.par_data  = par_data_q;
  assign bus.entry_err = err_q;
  assign bus.busy      = busy_q;
  assign bus.digit_cnt = cnt_q;
endmodule

// File: tb/tb_safe_code_entry.sv
// Table-driven bench for safe_code_entry with an expected-output queue.
module tb_safe_code_entry;
  localparam int N = 4;
  localparam int G = 5;
  localparam int T = 8;

  // stimulus code order: {rst, clear, enter, valid, bit}
  localparam logic [4:0] NOP = 5'b00000;
  localparam logic [4:0] K0  = 5'b00010;
  localparam logic [4:0] K1  = 5'b00011;
  localparam logic [4:0] ENT = 5'b00100;
  localparam logic [4:0] CLR = 5'b01000;
  localparam logic [4:0] RST = 5'b10000;

  typedef struct packed {
    logic       pv;
    logic [3:0] pd;
    logic       err;
    logic       busy;
    logic [2:0] cnt;
  } out_t;

  typedef struct packed {
    logic [4:0] in;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  safe_code_entry_if #(.N(N)) bus ();
  safe_code_entry #(.N(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_chk  = 0;
  int         n_pass = 0;
  vec_t       vecs[$];
  out_t       exp_q[$];
  logic [3:0] pd_now = 4'h0;

  function automatic out_t got();
    out_t o;
    o.pv   = bus.par_valid;
    o.pd   = bus.par_data;
    o.err  = bus.entry_err;
    o.busy = bus.busy;
    o.cnt  = bus.digit_cnt;
    return o;
  endfunction

  task automatic add(input logic [4:0] in, input logic pv, input logic err,
                     input logic busy, input int cnt);
    vec_t v;
    v.in       = in;
    v.exp.pv   = pv;
    v.exp.pd   = pd_now;
    v.exp.err  = err;
    v.exp.busy = busy;
    v.exp.cnt  = 3'(cnt);
    vecs.push_back(v);
  endtask

  task automatic add_keys(input logic [3:0] code);
    for (int i = 0; i < 4; i++) add(code[3-i] ? K1 : K0, 1'b0, 1'b0, 1'b0, i + 1);
  endtask

  task automatic add_gap();
    for (int i = 0; i < G - 1; i++) add(NOP, 1'b0, 1'b0, 1'b1, 0);
    add(NOP, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic drive(input logic [4:0] in);
    {rst, bus.key_clear, bus.key_enter, bus.key_valid, bus.key_bit} = in;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t a;
    a = got();
    n_chk++;
    if (a === exp) n_pass++;
    else $display("FAIL %s: got pv=%0b pd=%h err=%0b busy=%0b cnt=%0d, want pv=%0b pd=%h err=%0b busy=%0b cnt=%0d",
                  name, a.pv, a.pd, a.err, a.busy, a.cnt, exp.pv, exp.pd, exp.err, exp.busy, exp.cnt);
  endtask

  task automatic press(input logic [4:0] in);
    @(negedge clk);
    drive(in);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] code;
    int         w;
    int         b;
    int         pvs;
    drive(RST);

    // reset state
    add(RST, 0, 0, 0, 0);
    // 1011 then enter, full busy window
    add_keys(4'b1011); pd_now = 4'hB; add(ENT, 1, 0, 1, 0); add_gap();
    // short entry and enter from IDLE
    add(K1, 0, 0, 0, 1); add(K1, 0, 0, 0, 2); add(ENT, 0, 1, 0, 0); add(NOP, 0, 0, 0, 0);
    add(ENT, 0, 1, 0, 0); add(NOP, 0, 0, 0, 0);
    // overflow on 5th key, then a good 1100
    add_keys(4'b0101); add(K1, 0, 1, 0, 0);
    add_keys(4'b1100); pd_now = 4'hC; add(ENT, 1, 0, 1, 0); add_gap();
    // strobes during SEND/GAP are ignored
    add_keys(4'b0101); pd_now = 4'h5; add(ENT, 1, 0, 1, 0);
    add(K1, 0, 0, 1, 0); add(ENT, 0, 0, 1, 0); add(K0, 0, 0, 1, 0); add(CLR | K1, 0, 0, 1, 0);
    add(NOP, 0, 0, 0, 0);
    add_keys(4'b1110); pd_now = 4'hE; add(ENT, 1, 0, 1, 0); add_gap();
    // priority: clear beats enter, enter beats key
    add_keys(4'b1001); add(CLR | ENT, 0, 0, 0, 0);
    add_keys(4'b0011); pd_now = 4'h3; add(ENT | K1, 1, 0, 1, 0); add_gap();
    // clear in COLLECT, clear+key in IDLE
    add(K1, 0, 0, 0, 1); add(CLR, 0, 0, 0, 0); add(CLR | K1, 0, 0, 0, 0);
    // reset during SEND, then reset mid-collect discards the entry
    add_keys(4'b1000); pd_now = 4'h8; add(ENT, 1, 0, 1, 0);
    pd_now = 4'h0; add(RST, 0, 0, 0, 0);
    add(K1, 0, 0, 0, 1); add(RST, 0, 0, 0, 0);
    add_keys(4'b0110); pd_now = 4'h6; add(ENT, 1, 0, 1, 0); add_gap();
`ifdef SAFE_ENTRY_TIMEOUT_EN
    add(K1, 0, 0, 0, 1); add(K0, 0, 0, 0, 2);
    for (int i = 0; i < T - 2; i++) add(NOP, 0, 0, 0, 2);
    add(NOP, 0, 1, 0, 0); add(NOP, 0, 0, 0, 0);
`else
    add(K1, 0, 0, 0, 1); add(K0, 0, 0, 0, 2);
    for (int i = 0; i < 3 * T; i++) add(NOP, 0, 0, 0, 2);
    add(CLR, 0, 0, 0, 0);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].in);
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), exp_q.pop_front());
    end

    // random full code: bounded wait for the pulse, then measure the busy window
    code = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) press(code[3-i] ? K1 : K0);
    press(ENT);
    drive(NOP);
    w = 0;
    while (!bus.par_valid && w < 4) begin
      @(posedge clk); #1; w++;
    end
    n_chk++;
    if (bus.par_valid === 1'b1 && bus.par_data === code && w == 0) n_pass++;
    else $display("FAIL rand_send: got pv=%0b pd=%h after %0d cycles, want pv=1 pd=%h after 0",
                  bus.par_valid, bus.par_data, w, code);
    b = 0; pvs = 0;
    while (bus.busy === 1'b1 && b < 20) begin
      b++;
      if (bus.par_valid === 1'b1) pvs++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (b == G) n_pass++;
    else $display("FAIL busy_len: got %0d cycles, want %0d", b, G);
    n_chk++;
    if (pvs == 1) n_pass++;
    else $display("FAIL pv_width: got %0d cycles, want 1", pvs);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
